// File: rtl/mips32_data_mem_responder.sv
// Data-port memory responder for the MIPS32 core: one request at a time,
// programmable access latency, byte-lane stores, registered response.
module mips32_data_mem_responder #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned LATENCY    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned LANES = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]            state;
  logic [1:0]            state_nxt;
  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      cnt_nxt;
  logic                  capture_c;
  logic                  access_c;

  logic                  cap_we;
  logic [31:0]           cap_addr;
  logic [3:0]            cap_be;
  logic [31:0]           cap_wdata;

  logic                  misaligned_c;
  logic                  out_of_range_c;
  logic                  err_c;
  logic [ADDR_WIDTH-1:0] word_idx_c;
  logic [31:0]           rd_word_c;

  logic [31:0]           mem [DEPTH];

  // Next-state and per-cycle strobes
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capture_c = 1'b0;
    access_c  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          capture_c = 1'b1;
          cnt_nxt   = CNT_W'(LATENCY);
          state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - CNT_W'(1);
        end else begin
          access_c  = 1'b1;
          state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Address checks operate on the captured request only
  always_comb begin
    misaligned_c   = (cap_addr[1:0] != 2'b00);
    out_of_range_c = ((cap_addr >> (ADDR_WIDTH + 2)) != 32'd0);
    err_c          = misaligned_c | out_of_range_c;
    word_idx_c     = cap_addr[ADDR_WIDTH+1:2];
    rd_word_c      = mem[word_idx_c];
  end

  // State, handshake flags and response registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      cap_we    <= 1'b0;
      cap_addr  <= '0;
      cap_be    <= '0;
      cap_wdata <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      req_ready <= (state_nxt == ST_IDLE);
      rsp_valid <= (state_nxt == ST_RESP);
      if (capture_c) begin
        cap_we    <= req_we;
        cap_addr  <= req_addr;
        cap_be    <= req_be;
        cap_wdata <= req_wdata;
      end
      if (access_c) begin
        rsp_err   <= err_c;
        rsp_rdata <= (err_c || cap_we) ? 32'd0 : rd_word_c;
      end
    end
  end

  // Storage is not reset; a reset during BUSY forces IDLE so no write follows
  always_ff @(posedge clk) begin
    if (access_c && cap_we && !err_c) begin
      for (int i = 0; i < LANES; i++) begin
        if (cap_be[i]) begin
          mem[word_idx_c][8*i +: 8] <= cap_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule
